foc_sequencer: RTL and testbench
================================

# foc_sequencer

Parametrised control sequencer for the FOC datapath. It accepts one input sample through a valid/ready handshake and fires an ordered chain of N processing stages (clarke/cordic, park, pid, inverse park, inverse clarke, svm) with one-cycle start pulses. Each stage is either gated on its done signal or advanced after a fixed single cycle. Compared with the hard-coded top-level FSM it adds:

- stage count as a parameter
- a per-stage timeout watchdog with fault latching and clear
- abort
- per-sample cycle count

The block sits between the sample interface and the stage instances.

## Interface

Parameters:
- N_STAGES, 6, number of chained stages (2..16)
- DATA_W, 64, width of the captured sample bundle
- FIXED_MASK, 6'b001000, bit i = 1: stage i advances one cycle after its start pulse and ignores stage_done[i]
- TIMEOUT, 255, maximum WAIT cycles per stage before fault; 0 disables the watchdog
- CNT_W, 16, width of the cycle counter

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  sample present
- in_ready  out  1  sequencer idle and accepting
- in_data  in  DATA_W  sample bundle
- data_r  out  DATA_W  captured sample, stable until the next accept
- stage_start  out  N_STAGES  one-hot, one-cycle start pulse per stage
- stage_done  in  N_STAGES  stage completion levels
- stage_idx  out  $clog2(N_STAGES)  current stage index
- stage_rst  out  1  stage reset; pulse after completion or abort, held during fault
- done  out  1  one-cycle pulse when all stages have completed
- cycles  out  CNT_W  accept-to-done cycle count of the last completed sample, saturating
- abort  in  1  cancel the sequence in flight
- fault  out  1  watchdog fault latched
- fault_stage  out  $clog2(N_STAGES)  index of the stage that timed out
- fault_clr  in  1  clear the fault

## Operation

States: IDLE, START, WAIT, FLUSH, FAULT. All outputs are registered.

- **IDLE**
  - in_ready=1.
  - On in_valid: capture data_r<=in_data, set idx=0, clear the run counter, go to START.
- **START**
  - stage_start[idx]=1 for exactly one cycle.
  - Clear the timeout counter, go to WAIT.
- **WAIT**
  - Advance condition: FIXED_MASK[idx]=1, or stage_done[idx]=1.
  - On advance: if idx==N_STAGES-1 go to FLUSH; otherwise idx++ and go to START.
  - Otherwise increment the timeout counter. When TIMEOUT≠0 and the counter reaches TIMEOUT, go to FAULT with fault_stage<=idx.
- **FLUSH**
  - stage_rst=1 and done=1 for one cycle.
  - cycles<=run counter.
  - Go to IDLE.
- **FAULT**
  - fault=1, stage_rst held at 1, in_ready=0, no done.
  - fault_clr=1: next cycle go to IDLE; fault, stage_rst and idx return to 0.
- **Abort**
  - abort in START or WAIT: next cycle stage_rst=1 for one cycle, then go to IDLE.
  - No done, cycles unchanged.

Rules and edge cases:
- stage_done is sampled only in WAIT, for the current idx only. Other bits and pulses seen during START are ignored. Stages must hold done until stage_rst.
- The run counter increments every non-IDLE cycle and saturates at 2^CNT_W-1.
- abort and timeout in the same cycle: abort wins, no fault.
- abort in IDLE or FAULT is ignored.
- fault_clr outside FAULT is ignored.
- in_valid is ignored while in_ready=0.
- reset mid-sequence: next cycle the block is in IDLE. No stage_start or done is emitted, and stage_rst is not pulsed.
- Reset values: in_ready=1; all other outputs 0, including data_r, cycles and fault_stage.

## Timing

- Accept on cycle 0, when in_valid and in_ready are both 1.
- stage_start[0] is high on cycle 1.
- With every stage_done already high (or fixed), stage i starts on cycle 1+2i.
- done and stage_rst are high on cycle 2N_STAGES+1.
- in_ready returns on cycle 2N_STAGES+2. No back-to-back accept inside the FLUSH cycle.
- Each extra WAIT cycle on any stage adds one cycle to the latency and to cycles.
- The fault is entered TIMEOUT cycles after the start pulse. fault is visible on the following cycle.

## Test plan

- **Nominal sequence.** N=6, all stage_done tied high.
  - in_valid with in_data=0x1234.
  - Required: start pulses on cycles 1,3,5,7,9,11; done on cycle 13; cycles=13; data_r=0x1234; in_ready high on cycle 14.
- **Slow stage.** stage_done[1] rises 5 cycles after its start.
  - Required: done delayed by 4 cycles; cycles=17; stage 3 advances without its done (FIXED_MASK bit 3).
- **Timeout.** TIMEOUT=8, stage_done[4] held low.
  - Required: fault=1 and fault_stage=4; stage_rst held; in_ready=0; no done.
  - Then fault_clr → IDLE, and the next sample completes normally.
- **Abort.** abort in WAIT of stage 2.
  - Required: one stage_rst pulse, no done, cycles unchanged, in_ready=1 two cycles later.
- **Abort beats timeout.** abort in the same cycle the timeout would fire.
  - Required: no fault, and the abort behaviour above.
- **Reset mid-sequence.** reset asserted during stage 3.
  - Required: every output at its reset value the next cycle; in_valid on the following cycle is accepted.

Source files
------------

// File: rtl/foc_sequencer.sv
// Control sequencer for the FOC datapath: captures one sample, then walks a chain
// of start/done stages with a per-stage watchdog, abort and accept-to-done count.
module foc_sequencer #(
  parameter int                  N_STAGES   = 6,
  parameter int                  DATA_W     = 64,
  parameter logic [N_STAGES-1:0] FIXED_MASK = 6'b001000,
  parameter int                  TIMEOUT    = 255,
  parameter int                  CNT_W      = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_W-1:0]           in_data,
  output logic [DATA_W-1:0]           data_r,
  output logic [N_STAGES-1:0]         stage_start,
  input  logic [N_STAGES-1:0]         stage_done,
  output logic [$clog2(N_STAGES)-1:0] stage_idx,
  output logic                        stage_rst,
  output logic                        done,
  output logic [CNT_W-1:0]            cycles,
  input  logic                        abort,
  output logic                        fault,
  output logic [$clog2(N_STAGES)-1:0] fault_stage,
  input  logic                        fault_clr
);

  localparam int IDX_W = $clog2(N_STAGES);
  localparam int TO_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_STAGES - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_FLUSH, S_FAULT} state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [IDX_W-1:0]    fstage_q, fstage_d;
  logic [TO_W-1:0]     tmo_q, tmo_d;
  logic [CNT_W-1:0]    run_q, run_d, run_inc;
  logic [CNT_W-1:0]    cycles_q, cycles_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [N_STAGES-1:0] start_q, start_d;
  logic                ready_q, ready_d;
  logic                done_q, done_d;
  logic                srst_q, srst_d;
  logic                fault_q, fault_d;
  logic                advance, timed_out;

  assign run_inc   = (&run_q) ? run_q : run_q + CNT_W'(1);
  assign advance   = FIXED_MASK[idx_q] | stage_done[idx_q];
  assign timed_out = (TIMEOUT != 0) && ((int'(tmo_q) + 1) == TIMEOUT);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    fstage_d = fstage_q;
    tmo_d    = tmo_q;
    run_d    = (state_q != S_IDLE) ? run_inc : run_q;
    cycles_d = cycles_q;
    data_d   = data_q;
    done_d   = 1'b0;
    srst_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          data_d  = in_data;
          idx_d   = '0;
          run_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        tmo_d = '0;
        if (abort) begin
          srst_d  = 1'b1;
          state_d = S_FLUSH;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // abort takes priority over both advance and the watchdog
        if (abort) begin
          srst_d  = 1'b1;
          state_d = S_FLUSH;
        end else if (advance) begin
          if (idx_q == LAST_IDX) begin
            done_d  = 1'b1;
            srst_d  = 1'b1;
            state_d = S_FLUSH;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_START;
          end
        end else begin
          tmo_d = tmo_q + TO_W'(1);
          if (timed_out) begin
            fstage_d = idx_q;
            srst_d   = 1'b1;
            state_d  = S_FAULT;
          end
        end
      end
      S_FLUSH: begin
        // done_q distinguishes a completed run from an aborted one
        if (done_q) begin
          cycles_d = run_inc;
        end
        state_d = S_IDLE;
      end
      S_FAULT: begin
        srst_d = 1'b1;
        if (fault_clr) begin
          srst_d  = 1'b0;
          idx_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_IDLE);
    fault_d = (state_d == S_FAULT);
  end

  generate
    for (genvar gi = 0; gi < N_STAGES; gi++) begin : g_start
      assign start_d[gi] = (state_d == S_START) && (idx_d == IDX_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      fstage_q <= '0;
      tmo_q    <= '0;
      run_q    <= '0;
      cycles_q <= '0;
      data_q   <= '0;
      start_q  <= '0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      srst_q   <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      fstage_q <= fstage_d;
      tmo_q    <= tmo_d;
      run_q    <= run_d;
      cycles_q <= cycles_d;
      data_q   <= data_d;
      start_q  <= start_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      srst_q   <= srst_d;
      fault_q  <= fault_d;
    end
  end

  assign in_ready    = ready_q;
  assign data_r      = data_q;
  assign stage_start = start_q;
  assign stage_idx   = idx_q;
  assign stage_rst   = srst_q;
  assign done        = done_q;
  assign cycles      = cycles_q;
  assign fault       = fault_q;
  assign fault_stage = fstage_q;

endmodule

// File: tb/tb_foc_sequencer.sv
// Bench for foc_sequencer: a per-sample schedule model predicts every output cycle by cycle.
module tb_foc_sequencer;

  localparam int N   = 6;
  localparam int DW  = 64;
  localparam int TO  = 8;
  localparam int CW  = 5;
  localparam int IW  = $clog2(N);
  localparam int SAT = (1 << CW) - 1;
  localparam logic [N-1:0] FM = 6'b001000;
  localparam int K_NORMAL = 0;
  localparam int K_ABORT  = 1;
  localparam int K_RESET  = 2;

  logic          clk = 1'b0;
  logic          reset, in_valid, in_ready, done, stage_rst, abort, fault, fault_clr;
  logic [DW-1:0] in_data, data_r;
  logic [N-1:0]  stage_start, stage_done;
  logic [IW-1:0] stage_idx, fault_stage;
  logic [CW-1:0] cycles;

  foc_sequencer #(
    .N_STAGES(N), .DATA_W(DW), .FIXED_MASK(FM), .TIMEOUT(TO), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .data_r(data_r), .stage_start(stage_start),
    .stage_done(stage_done), .stage_idx(stage_idx), .stage_rst(stage_rst),
    .done(done), .cycles(cycles), .abort(abort), .fault(fault),
    .fault_stage(fault_stage), .fault_clr(fault_clr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int delay [N];
  int s_at [N];
  bit active [N];
  logic [CW-1:0] exp_cycles = '0;
  logic [DW-1:0] exp_data = '0;
  logic [IW-1:0] exp_fstage = '0;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s (cycle %0d): observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // Stage models: done rises delay[i] cycles after the start pulse and holds until
  // stage_rst; bits the sequencer must ignore carry random noise.
  task automatic drive_stages();
    for (int i = 0; i < N; i++) begin
      if (stage_rst) active[i] = 1'b0;
      if (stage_start[i]) begin
        active[i] = 1'b1;
        s_at[i] = cyc;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (FM[i] || !active[i] || cyc == s_at[i])
        stage_done[i] = 1'($urandom_range(0, 1));
      else
        stage_done[i] = (cyc >= s_at[i] + delay[i]);
    end
  endtask

  task automatic idle_gap(input int n);
    for (int g = 0; g < n; g++) begin
      in_valid  = 1'b0;
      abort     = 1'($urandom_range(0, 1));
      fault_clr = 1'($urandom_range(0, 1));
      tick();
      check("idle_ready", in_ready, 1'b1);
      check("idle_start", stage_start, '0);
      check("idle_done", done, 1'b0);
      check("idle_fault", fault, 1'b0);
      drive_stages();
    end
    abort = 1'b0;
    fault_clr = 1'b0;
  endtask

  // ev_req: -1 random event cycle, -2 the last decision cycle, else that cycle.
  task automatic run_txn(input int kind, input int ev_req, input logic [DW-1:0] data);
    int start_c [N];
    int n_st, c, done_c, fault_c, fault_i, last_dec, ev, end_c, clr_c, live, exp_idx;
    logic [N-1:0] exp_start;
    bit in_fault, exp_rst;
    c = 1; n_st = 0; done_c = -1; fault_c = -1; fault_i = 0;
    for (int i = 0; i < N; i++) begin
      if (fault_c < 0) begin
        start_c[i] = c;
        n_st++;
        if (!FM[i] && delay[i] > TO) begin
          fault_c = c + TO + 1;
          fault_i = i;
        end else begin
          c = c + 1 + (FM[i] ? 1 : delay[i]);
        end
      end
    end
    if (fault_c < 0) done_c = c;
    last_dec = (fault_c < 0) ? done_c - 1 : fault_c - 1;
    if (kind == K_NORMAL) ev = 1 << 30;
    else if (ev_req == -1) ev = int'($urandom_range(1, last_dec));
    else if (ev_req == -2) ev = last_dec;
    else ev = ev_req;
    clr_c = (fault_c > 0) ? fault_c + int'($urandom_range(0, 3)) : -1;
    if (kind == K_ABORT) end_c = ev + 2;
    else if (kind == K_RESET) end_c = ev + 1;
    else if (fault_c > 0) end_c = clr_c + 1;
    else end_c = done_c + 1;

    cyc = 0;
    for (int i = 0; i < N; i++) active[i] = 1'b0;
    check("ready_at_accept", in_ready, 1'b1);
    in_valid  = 1'b1;
    in_data   = data;
    reset     = 1'b0;
    abort     = 1'($urandom_range(0, 1));
    fault_clr = 1'($urandom_range(0, 1));
    drive_stages();

    for (int k = 1; k <= end_c; k++) begin
      tick();
      exp_start = '0;
      live = 0;
      for (int i = 0; i < n_st; i++) begin
        if (start_c[i] <= ev && start_c[i] == k) exp_start[i] = 1'b1;
        if (start_c[i] <= ev && start_c[i] <= k) live++;
      end
      in_fault = (kind == K_NORMAL) && (fault_c > 0) && (k >= fault_c) && (k < end_c);
      exp_idx = live - 1;
      if (k == end_c && (kind == K_RESET || (kind == K_NORMAL && fault_c > 0))) exp_idx = 0;
      exp_rst = (kind == K_NORMAL && fault_c < 0 && k == done_c) || in_fault ||
                (kind == K_ABORT && k == ev + 1);
      if (in_fault) exp_fstage = IW'(fault_i);
      if (k == end_c) begin
        if (kind == K_RESET) begin
          exp_cycles = '0;
          exp_data   = '0;
          exp_fstage = '0;
        end else begin
          exp_data = data;
          if (kind == K_NORMAL && fault_c < 0) exp_cycles = (done_c > SAT) ? CW'(SAT) : CW'(done_c);
        end
      end
      check("stage_start", stage_start, exp_start);
      check("in_ready", in_ready, k == end_c);
      check("done", done, kind == K_NORMAL && fault_c < 0 && k == done_c);
      check("stage_rst", stage_rst, exp_rst);
      check("fault", fault, in_fault);
      check("stage_idx", stage_idx, 64'(exp_idx));
      if (in_fault) check("fault_stage", fault_stage, exp_fstage);
      if (k == end_c) begin
        check("cycles", cycles, exp_cycles);
        check("data_r", data_r, exp_data);
        check("fault_stage_end", fault_stage, exp_fstage);
      end
      drive_stages();
      if (k == end_c) begin
        in_valid = 1'b0; abort = 1'b0; fault_clr = 1'b0; reset = 1'b0;
      end else begin
        in_valid  = 1'($urandom_range(0, 1));
        in_data   = {$urandom, $urandom};
        reset     = (kind == K_RESET && k == ev);
        abort     = (kind == K_ABORT && k == ev) || (in_fault && $urandom_range(0, 1) == 1);
        fault_clr = in_fault ? (k == clr_c) : ($urandom_range(0, 1) == 1);
      end
    end
  endtask

  task automatic set_delays(input int d);
    for (int i = 0; i < N; i++) delay[i] = d;
  endtask

  initial begin
    int kind, pick;
    reset = 1'b1; in_valid = 1'b0; in_data = '0; abort = 1'b0; fault_clr = 1'b0;
    stage_done = '0;
    for (int i = 0; i < N; i++) begin
      delay[i] = 1; s_at[i] = 0; active[i] = 1'b0;
    end
    tick();
    tick();
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_stage_start", stage_start, '0);
    check("rst_done", done, 1'b0);
    check("rst_stage_rst", stage_rst, 1'b0);
    check("rst_fault", fault, 1'b0);
    check("rst_fault_stage", fault_stage, '0);
    check("rst_data_r", data_r, '0);
    check("rst_cycles", cycles, '0);
    check("rst_stage_idx", stage_idx, '0);

    // nominal, fixed stage 3 never raises done
    set_delays(1); delay[3] = 99;
    run_txn(K_NORMAL, 0, 64'h1234);
    // slow stage 1, then a stage that finishes exactly at the watchdog limit
    set_delays(1); delay[1] = 5;
    run_txn(K_NORMAL, 0, {$urandom, $urandom});
    set_delays(1); delay[2] = TO;
    run_txn(K_NORMAL, 0, {$urandom, $urandom});
    // timeout on stage 4, cleared, then a normal sample
    set_delays(1); delay[4] = 99;
    run_txn(K_NORMAL, 0, {$urandom, $urandom});
    set_delays(1);
    run_txn(K_NORMAL, 0, {$urandom, $urandom});
    // abort in WAIT of stage 2
    run_txn(K_ABORT, 6, {$urandom, $urandom});
    idle_gap(2);
    // abort in the cycle the watchdog would fire
    set_delays(1); delay[4] = 99;
    run_txn(K_ABORT, -2, {$urandom, $urandom});
    // reset during stage 3, next sample accepted immediately
    set_delays(1);
    run_txn(K_RESET, 8, {$urandom, $urandom});
    run_txn(K_NORMAL, 0, {$urandom, $urandom});

    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < N; i++) delay[i] = int'($urandom_range(1, TO));
      if ($urandom_range(0, 4) == 0) begin
        pick = int'($urandom_range(0, N - 1));
        if (FM[pick]) pick = 0;
        delay[pick] = TO + 1 + int'($urandom_range(0, 3));
      end
      kind = int'($urandom_range(0, 3));
      if (kind == 3) kind = K_NORMAL;
      run_txn(kind, -1, {$urandom, $urandom});
      idle_gap(int'($urandom_range(0, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
